// File: rtl/sha1_search_tile.sv
// SHA-1 nonce search tile: walks a range of nonces spliced into a
// pre-padded message, hashes each candidate with an iterative SHA-1
// core and reports masked digest matches over a valid/ready stream.

// Iterative SHA-1 compression core: one round per clock, 80 rounds per block.
// init starts from the standard IV, next chains from the previous digest.
module sha1_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block,
  output logic         ready,
  output logic [159:0] digest,
  output logic         digest_valid
);
  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  logic         busy;
  logic [6:0]   round;
  logic [511:0] w_q;
  logic [31:0]  a, b, c, d, e;
  logic [159:0] h_q;
  logic [31:0]  f, k, temp, w_new;
  logic         start;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  assign start  = (init | next) & ~busy;
  assign ready  = ~busy;
  assign digest = h_q;

  // Round function, constant and next message-schedule word (16-word window, word 0 at top).
  always_comb begin
    // NOTE: f and k are assigned on every branch so no latch is inferred.
    if (round < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5a827999;
    end else if (round < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ed9eba1;
    end else if (round < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8f1bbcdc;
    end else begin
      f = b ^ c ^ d;
      k = 32'hca62c1d6;
    end
    temp  = rotl(a, 5) + f + e + k + w_q[511:480];
    w_new = rotl(w_q[95:64] ^ w_q[255:224] ^ w_q[447:416] ^ w_q[511:480], 1);
  end

  // Control: round counter and busy/valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      busy         <= 1'b0;
      round        <= '0;
      digest_valid <= 1'b0;
    end else if (start) begin
      busy         <= 1'b1;
      round        <= '0;
      digest_valid <= 1'b0;
    end else if (busy) begin
      round <= round + 7'd1;
      if (round == 7'd79) begin
        busy         <= 1'b0;
        digest_valid <= 1'b1;
      end
    end
  end

  // Datapath: working variables, schedule window and chaining value.
  // NOTE: datapath regs are not reset; init/next always loads them before use.
  always_ff @(posedge clk) begin
    if (start) begin
      w_q             <= block;
      {a, b, c, d, e} <= init ? IV : h_q;
      if (init) h_q <= IV;
    end else if (busy) begin
      w_q             <= {w_q[479:0], w_new};
      {a, b, c, d, e} <= {temp, a, rotl(b, 30), c, d};
      if (round == 7'd79)
        h_q <= {h_q[159:128] + temp, h_q[127:96] + a, h_q[95:64] + rotl(b, 30),
                h_q[63:32] + c, h_q[31:0] + d};
    end
  end
endmodule

module sha1_search_tile #(
  parameter int BLOCKS      = 2,
  parameter int NONCE_W     = 32,
  parameter int NONCE_POS   = 0,
  parameter int STOP_ON_HIT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  job_val_i,
  output logic                  job_rdy_o,
  input  logic [BLOCKS*512-1:0] job_msg_i,
  input  logic [NONCE_W-1:0]    job_nonce_i,
  input  logic [NONCE_W-1:0]    job_count_i,
  input  logic [159:0]          dgst_i,
  input  logic [159:0]          dgst_mask_i,
  output logic                  res_val_o,
  input  logic                  res_rdy_i,
  output logic                  res_hit_o,
  output logic                  res_last_o,
  output logic [NONCE_W-1:0]    res_nonce_o,
  output logic [159:0]          res_dgst_o
);
  localparam int MSG_W = BLOCKS * 512;
  localparam int BLK_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int IDX_W = $clog2(MSG_W);
  localparam logic [MSG_W-1:0] FIELD =
    {{(MSG_W-NONCE_W){1'b0}}, {NONCE_W{1'b1}}} << NONCE_POS;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, REPORT} state_t;

  state_t             state, state_d;
  logic [MSG_W-1:0]   msg_q, msg_n;
  logic [NONCE_W-1:0] nonce_q, count_q;
  logic [159:0]       tgt_q, mask_q;
  logic [BLK_W-1:0]   blk_id;
  logic [IDX_W-1:0]   blk_base;
  logic               core_init, core_next, core_ready, core_valid;
  logic [511:0]       core_block;
  logic [159:0]       core_digest;
  logic               accept, hit, blk_last, pulse;

  sha1_core u_core (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .init         (core_init),
    .next         (core_next),
    .block        (core_block),
    .ready        (core_ready),
    .digest       (core_digest),
    .digest_valid (core_valid)
  );

  assign hit      = ~|((core_digest ^ tgt_q) & mask_q);
  assign blk_last = (int'(blk_id) == BLOCKS - 1);
  assign pulse    = core_init | core_next;

  // Candidate message with the current nonce spliced in; pick block blk_id.
  always_comb begin
    msg_n      = (msg_q & ~FIELD) | (MSG_W'(nonce_q) << NONCE_POS);
    blk_base   = IDX_W'(MSG_W - 1 - 512 * int'(blk_id));
    core_block = msg_n[blk_base -: 512];
  end

  // Next-state logic of the search sequencer.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE:
        if (job_rdy_o && job_val_i) begin
          accept  = 1'b1;
          state_d = (job_count_i == '0) ? REPORT : ISSUE;
        end
      ISSUE:
        if (core_ready) state_d = WAIT;
      WAIT:
        // The core only drops ready the cycle after the pulse, so skip that cycle.
        if (!pulse && core_ready && core_valid) state_d = blk_last ? CHECK : ISSUE;
      CHECK:
        state_d = (hit || count_q == NONCE_W'(1)) ? REPORT : ISSUE;
      REPORT:
        if (res_rdy_i) state_d = res_last_o ? IDLE : ISSUE;
      default:
        state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_d;
  end

  // Job registers, core strobes and registered result record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_rdy_o   <= 1'b0;
      res_val_o   <= 1'b0;
      res_hit_o   <= 1'b0;
      res_last_o  <= 1'b0;
      res_nonce_o <= '0;
      res_dgst_o  <= '0;
      blk_id      <= '0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      msg_q       <= '0;
      nonce_q     <= '0;
      count_q     <= '0;
      tgt_q       <= '0;
      mask_q      <= '0;
    end else begin
      job_rdy_o <= (state_d == IDLE);
      res_val_o <= (state_d == REPORT);
      core_init <= 1'b0;
      core_next <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            msg_q       <= job_msg_i;
            nonce_q     <= job_nonce_i;
            count_q     <= job_count_i;
            tgt_q       <= dgst_i;
            mask_q      <= dgst_mask_i;
            blk_id      <= '0;
            // Only visible when the job is empty: no-hit final record.
            res_hit_o   <= 1'b0;
            res_last_o  <= 1'b1;
            res_nonce_o <= job_nonce_i;
            res_dgst_o  <= '0;
          end
        ISSUE:
          if (core_ready) begin
            core_init <= (blk_id == '0);
            core_next <= (blk_id != '0);
          end
        WAIT:
          if (state_d == ISSUE) blk_id <= blk_id + 1'b1;
        CHECK: begin
          nonce_q <= nonce_q + 1'b1;
          count_q <= count_q - 1'b1;
          blk_id  <= '0;
          if (hit) begin
            res_hit_o   <= 1'b1;
            res_last_o  <= (STOP_ON_HIT != 0) || (count_q == NONCE_W'(1));
            res_nonce_o <= nonce_q;
            res_dgst_o  <= core_digest;
          end else begin
            res_hit_o   <= 1'b0;
            res_last_o  <= 1'b1;
            res_nonce_o <= nonce_q + 1'b1;
            res_dgst_o  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha1_search_tile.sv
// Bench for sha1_search_tile: two instances (1-block stop-on-hit, and
// 2-block report-all), a constant vector table, hand sequences for
// stalls, nonce wrap and mid-job reset, and random jobs against a
// FIPS-style SHA-1 reference model.
module tb_sha1_search_tile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           job_val, res_rdy;
  bit             sel;
  logic [1023:0]  job_msg;
  logic [7:0]     job_nonce, job_count;
  logic [159:0]   dgst, dgst_mask;

  logic val_a, val_b, rr_a, rr_b;
  logic rdy_a, rval_a, hit_a, last_a, rdy_b, rval_b, hit_b, last_b;
  logic [7:0]   nonce_a, nonce_b;
  logic [159:0] dg_a, dg_b;

  assign val_a = job_val & ~sel;
  assign val_b = job_val & sel;
  assign rr_a  = res_rdy & ~sel;
  assign rr_b  = res_rdy & sel;

  logic rdy_s, rval_s, hit_s, last_s;
  logic [7:0]   nonce_s;
  logic [159:0] dg_s;
  assign rdy_s   = sel ? rdy_b : rdy_a;
  assign rval_s  = sel ? rval_b : rval_a;
  assign hit_s   = sel ? hit_b : hit_a;
  assign last_s  = sel ? last_b : last_a;
  assign nonce_s = sel ? nonce_b : nonce_a;
  assign dg_s    = sel ? dg_b : dg_a;

  sha1_search_tile #(.BLOCKS(1), .NONCE_W(8), .NONCE_POS(488), .STOP_ON_HIT(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .job_val_i(val_a), .job_rdy_o(rdy_a),
    .job_msg_i(job_msg[511:0]), .job_nonce_i(job_nonce), .job_count_i(job_count),
    .dgst_i(dgst), .dgst_mask_i(dgst_mask), .res_val_o(rval_a), .res_rdy_i(rr_a),
    .res_hit_o(hit_a), .res_last_o(last_a), .res_nonce_o(nonce_a), .res_dgst_o(dg_a)
  );

  sha1_search_tile #(.BLOCKS(2), .NONCE_W(8), .NONCE_POS(0), .STOP_ON_HIT(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .job_val_i(val_b), .job_rdy_o(rdy_b),
    .job_msg_i(job_msg), .job_nonce_i(job_nonce), .job_count_i(job_count),
    .dgst_i(dgst), .dgst_mask_i(dgst_mask), .res_val_o(rval_b), .res_rdy_i(rr_b),
    .res_hit_o(hit_b), .res_last_o(last_b), .res_nonce_o(nonce_b), .res_dgst_o(dg_b)
  );

  // Core strobe counters, observed through the hierarchy.
  int init_a = 0, init_b = 0, next_b = 0;
  always @(posedge clk) begin
    if (dut_a.core_init) init_a <= init_a + 1;
    if (dut_b.core_init) init_b <= init_b + 1;
    if (dut_b.core_next) next_b <= next_b + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [159:0] sha1_ref(input logic [1023:0] m, input int nblk);
    logic [31:0] h [5];
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    h[0] = 32'h67452301; h[1] = 32'hefcdab89; h[2] = 32'h98badcfe;
    h[3] = 32'h10325476; h[4] = 32'hc3d2e1f0;
    for (int blk = 0; blk < nblk; blk++) begin
      for (int i = 0; i < 16; i++) w[i] = m[(nblk - blk) * 512 - 1 - 32 * i -: 32];
      for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
      for (int i = 0; i < 80; i++) begin
        if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
        else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
        else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
        else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
        t = rol(a, 5) + f + e + k + w[i];
        e = d; d = c; c = rol(b, 30); b = a; a = t;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
    end
    return {h[0], h[1], h[2], h[3], h[4]};
  endfunction

  function automatic logic [1023:0] with_nonce(input logic [1023:0] m, input int pos,
                                               input logic [7:0] n);
    logic [1023:0] r;
    r = m;
    r[pos +: 8] = n;
    return r;
  endfunction

  typedef struct {
    bit           hit;
    bit           last;
    logic [7:0]   nonce;
    logic [159:0] dgst;
  } rec_t;

  rec_t exp_q[$];

  // Expected record stream of a job: try nonces in order, report per instance policy.
  task automatic model_job(input bit s, input logic [1023:0] m, input logic [7:0] start,
                           input logic [7:0] cnt, input logic [159:0] tgt,
                           input logic [159:0] mask);
    int nblk, pos, left;
    bit stop, hit;
    logic [7:0] n, nn;
    logic [159:0] d;
    rec_t r;
    nblk = s ? 2 : 1;
    pos  = s ? 0 : 488;
    stop = !s;
    n    = start;
    left = int'(cnt);
    if (cnt == 8'd0) begin
      r = '{hit: 1'b0, last: 1'b1, nonce: start, dgst: 160'd0};
      exp_q.push_back(r);
      return;
    end
    while (left > 0) begin
      d = sha1_ref(with_nonce(m, pos, n), nblk);
      left--;
      hit = (((d ^ tgt) & mask) == 160'd0);
      nn  = n + 8'd1;
      if (hit) begin
        r = '{hit: 1'b1, last: (stop || left == 0), nonce: n, dgst: d};
        exp_q.push_back(r);
        if (stop) return;
      end else if (left == 0) begin
        r = '{hit: 1'b0, last: 1'b1, nonce: nn, dgst: 160'd0};
        exp_q.push_back(r);
      end
      n = nn;
    end
  endtask

  // ---------------- job driver ----------------
  task automatic run_job(input bit s, input logic [1023:0] m, input logic [7:0] start,
                         input logic [7:0] cnt, input logic [159:0] tgt,
                         input logic [159:0] mask, input int stall, input bit use_model,
                         input int exp_inits, input int exp_nexts, input string tag);
    int t, lat, i0, n0;
    bit got_last, first, stable;
    rec_t r;
    if (use_model) begin
      exp_q.delete();
      model_job(s, m, start, cnt, tgt, mask);
    end
    @(negedge clk);
    sel = s;
    job_msg = m; job_nonce = start; job_count = cnt; dgst = tgt; dgst_mask = mask;
    i0 = s ? init_b : init_a;
    n0 = next_b;
    job_val = 1'b1;
    t = 0;
    while (!rdy_s && t < 200) begin @(negedge clk); t++; end
    if (!rdy_s) begin
      job_val = 1'b0;
      fail({tag, " accept"});
      return;
    end
    @(negedge clk);
    job_val = 1'b0;
    // Scramble the job inputs: the tile must work from its latched copy.
    job_msg = ~m; job_nonce = ~start; job_count = 8'hff; dgst = ~tgt; dgst_mask = ~mask;
    lat = 1; got_last = 1'b0; first = 1'b1; t = 0;
    while (!got_last && t < 8000) begin
      if (rval_s) begin
        if (exp_q.size() == 0) begin
          fail({tag, " unexpected extra record"});
          break;
        end
        r = exp_q.pop_front();
        if (first && cnt == 8'd0) check({tag, " empty-job latency<=2"}, 160'(lat <= 2), 160'd1);
        first = 1'b0;
        check({tag, " hit"},   160'(hit_s),   160'(r.hit));
        check({tag, " last"},  160'(last_s),  160'(r.last));
        check({tag, " nonce"}, 160'(nonce_s), 160'(r.nonce));
        check({tag, " dgst"},  dg_s,          r.dgst);
        stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
          @(negedge clk); t++;
          if (!rval_s || hit_s !== r.hit || last_s !== r.last || nonce_s !== r.nonce ||
              dg_s !== r.dgst) stable = 1'b0;
        end
        if (stall > 0) check({tag, " record stable while stalled"}, 160'(stable), 160'd1);
        res_rdy = 1'b1;
        @(negedge clk); t++;
        res_rdy = 1'b0;
        got_last = r.last;
      end else begin
        @(negedge clk); t++; lat++;
      end
    end
    if (!got_last) fail({tag, " final record"});
    check({tag, " records outstanding"}, 160'(exp_q.size()), 160'd0);
    repeat (3) @(negedge clk);
    check({tag, " idle after job {val,rdy}"}, 160'({rval_s, rdy_s}), 160'd1);
    if (exp_inits >= 0)
      check({tag, " init pulses"}, 160'((s ? init_b : init_a) - i0), 160'(exp_inits));
    if (exp_nexts >= 0)
      check({tag, " next pulses"}, 160'(next_b - n0), 160'(exp_nexts));
  endtask

  // ---------------- constant vectors ----------------
  localparam logic [1023:0] ABC_MSG = {512'd0, 32'h61626380, 448'd0, 32'h00000018};
  localparam logic [1023:0] B_MSG   = {16{64'h0123456789abcdef}};
  localparam logic [159:0]  ABC_DG  = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0]  NUL_DG  = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
  localparam logic [159:0]  ONES    = {160{1'b1}};

  typedef struct {
    bit            s;
    logic [1023:0] msg;
    logic [7:0]    start;
    logic [7:0]    cnt;
    logic [159:0]  tgt;
    logic [159:0]  mask;
    bit            e_hit;
    logic [7:0]    e_nonce;
    logic [159:0]  e_dgst;
    int            e_inits;
    int            e_nexts;
    string         tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1023:0] m;
    logic [7:0] st, cn;
    logic [159:0] tg, mk;
    bit s;
    int t, i0, pos, nblk;
    rec_t r;

    vecs[0] = '{0, ABC_MSG, 8'h60, 8'd8, ABC_DG, ONES, 1, 8'h63, ABC_DG, 4, -1, "abc hit"};
    vecs[1] = '{0, ABC_MSG, 8'h60, 8'd8, NUL_DG, ONES, 0, 8'h68, 160'd0, 8, -1, "abc miss"};
    vecs[2] = '{0, ABC_MSG, 8'h42, 8'd0, ABC_DG, ONES, 0, 8'h42, 160'd0, 0, -1, "empty job"};
    vecs[3] = '{0, ABC_MSG, 8'h63, 8'd1, ABC_DG, ONES, 1, 8'h63, ABC_DG, 1, -1, "first hit"};
    vecs[4] = '{0, ABC_MSG, 8'hfe, 8'd2, NUL_DG, ONES, 0, 8'h00, 160'd0, 2, -1, "wrap 1blk"};
    vecs[5] = '{1, B_MSG,   8'hff, 8'd2, 160'd0, ONES, 0, 8'h01, 160'd0, 2, 2,  "wrap 2blk"};

    rst_n = 1'b0; job_val = 1'b0; res_rdy = 1'b0; sel = 1'b0;
    job_msg = '0; job_nonce = '0; job_count = '0; dgst = '0; dgst_mask = '0;
    repeat (3) @(negedge clk);
    check("reset job_rdy",  160'({rdy_a, rdy_b}),   160'd0);
    check("reset res_val",  160'({rval_a, rval_b}), 160'd0);
    check("reset hit/last", 160'({hit_a, last_a, hit_b, last_b}), 160'd0);
    check("reset nonce",    160'({nonce_a, nonce_b}), 160'd0);
    check("reset dgst",     dg_a | dg_b, 160'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("job_rdy after reset", 160'({rdy_a, rdy_b}), 160'd3);

    for (int i = 0; i < 6; i++) begin
      exp_q.delete();
      r = '{hit: vecs[i].e_hit, last: 1'b1, nonce: vecs[i].e_nonce, dgst: vecs[i].e_dgst};
      exp_q.push_back(r);
      run_job(vecs[i].s, vecs[i].msg, vecs[i].start, vecs[i].cnt, vecs[i].tgt, vecs[i].mask,
              2, 1'b0, vecs[i].e_inits, vecs[i].e_nexts, vecs[i].tag);
    end

    // Report-every-match mode: mask 0 makes every candidate a hit; long stalls.
    run_job(1'b1, B_MSG ^ {32{32'h5a5a1234}}, 8'h10, 8'd3, 160'd0, 160'd0, 10, 1'b1, 3, 3,
            "all hits stalled");

    // Random jobs against the reference model.
    for (int j = 0; j < 8; j++) begin
      s    = j[0];
      nblk = s ? 2 : 1;
      pos  = s ? 0 : 488;
      for (int w = 0; w < 32; w++) m[32 * w +: 32] = $urandom;
      st = 8'($urandom);
      cn = 8'($urandom_range(1, 4));
      for (int w = 0; w < 5; w++) mk[32 * w +: 32] = $urandom;
      if ($urandom_range(0, 1) == 1)
        tg = sha1_ref(with_nonce(m, pos, st + 8'($urandom_range(0, int'(cn) - 1))), nblk);
      else
        for (int w = 0; w < 5; w++) tg[32 * w +: 32] = $urandom;
      run_job(s, m, st, cn, tg, mk, $urandom_range(0, 3), 1'b1, -1, -1, "random job");
    end

    // Reset while the core is busy on a candidate: job dropped, no record.
    @(negedge clk);
    sel = 1'b0;
    job_msg = ABC_MSG; job_nonce = 8'h60; job_count = 8'd8; dgst = ABC_DG; dgst_mask = ONES;
    i0 = init_a;
    job_val = 1'b1;
    @(negedge clk);
    job_val = 1'b0;
    t = 0;
    while (init_a == i0 && t < 50) begin @(negedge clk); t++; end
    if (init_a == i0) fail("reset test init pulse");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-job reset outputs", 160'({rdy_a, rval_a, hit_a, last_a, nonce_a}), 160'd0);
    check("mid-job reset dgst", dg_a, 160'd0);
    check("mid-job reset strobes/blk_id", 160'({dut_a.core_init, dut_a.core_next, dut_a.blk_id}),
          160'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rval_a) t++;
    end
    check("no record after abandoned job", 160'(t), 160'd0);
    check("ready after abandoned job", 160'(rdy_a), 160'd1);
    exp_q.delete();
    r = '{hit: 1'b1, last: 1'b1, nonce: 8'h63, dgst: ABC_DG};
    exp_q.push_back(r);
    run_job(1'b0, ABC_MSG, 8'h60, 8'd8, ABC_DG, ONES, 1, 1'b0, 4, -1, "job after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sha1_search_tile.md
SHA1_SEARCH_TILE -- requirements
Module: sha1_search_tile

Interface
REQ-001 SHALL have parameter BLOCKS, default 2, meaning number of 512-bit blocks in the pre-padded message (>=1).
REQ-002 SHALL have parameter NONCE_W, default 32, meaning width of the candidate nonce field.
REQ-003 SHALL have parameter NONCE_POS, default 0, meaning LSB bit offset of the nonce field within the message; NONCE_POS+NONCE_W <= BLOCKS*512.
REQ-004 SHALL have parameter STOP_ON_HIT, default 1, meaning 1 = end job at first match, 0 = report every match.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port job_val_i, input, 1 bit: job offered.
REQ-008 SHALL have port job_rdy_o, output, 1 bit: job accepted when high with job_val_i.
REQ-009 SHALL have port job_msg_i, input, BLOCKS*512 bits: padded message; bit BLOCKS*512-1 is the first message bit; block k = bits [(BLOCKS-k)*512-1 -: 512].
REQ-010 SHALL have port job_nonce_i, input, NONCE_W bits: first candidate nonce.
REQ-011 SHALL have port job_count_i, input, NONCE_W bits: number of candidates to try.
REQ-012 SHALL have port dgst_i, input, 160 bits: target digest.
REQ-013 SHALL have port dgst_mask_i, input, 160 bits: compare mask, 1 = bit must match.
REQ-014 SHALL have port res_val_o, output, 1 bit: result record valid.
REQ-015 SHALL have port res_rdy_i, input, 1 bit: result consumer ready.
REQ-016 SHALL have port res_hit_o, output, 1 bit: record is a match.
REQ-017 SHALL have port res_last_o, output, 1 bit: final record of the job.
REQ-018 SHALL have port res_nonce_o, output, NONCE_W bits: nonce of the match, or next untried nonce when res_hit_o=0.
REQ-019 SHALL have port res_dgst_o, output, 160 bits: digest of the matching candidate, 0 when res_hit_o=0.

Function
REQ-020 SHALL instantiate sha1_core, driving init, next and block, and consuming ready, digest and digest_valid.
REQ-021 SHALL latch job_msg_i, job_nonce_i, job_count_i, dgst_i and dgst_mask_i on the job handshake, ignoring later input changes until the job ends.
REQ-022 SHALL use FSM states IDLE, ISSUE, WAIT, CHECK, REPORT.
REQ-023 IDLE: job_rdy_o=1; on accept SHALL go to REPORT (no-hit, last) if count=0, else to ISSUE with blk_id=0.
REQ-024 ISSUE: SHALL hold for core ready=1, then pulse init (blk_id=0) or next (blk_id>0) for exactly one cycle with block k of the message (nonce field replaced by the current nonce), then go to WAIT.
REQ-025 WAIT: SHALL ignore core ready in the first cycle after the pulse, then on ready=1 SHALL go to ISSUE with blk_id+1 if blk_id<BLOCKS-1, else to CHECK.
REQ-026 CHECK (one cycle): hit = ~|((digest ^ target) & mask); SHALL advance nonce (mod 2^NONCE_W, wrap permitted) and decrement the remaining count.
REQ-027 From CHECK: hit -> REPORT (last = STOP_ON_HIT or count exhausted); no hit and count exhausted -> REPORT (no-hit, last); otherwise -> ISSUE with blk_id=0.
REQ-028 REPORT: SHALL hold res_val_o=1 with stable fields until res_rdy_i; then IDLE if last, else ISSUE with blk_id=0.
REQ-029 With STOP_ON_HIT=0, a hit on the final candidate SHALL produce one record with hit=1 and last=1; no separate no-hit record.
REQ-030 Outputs SHALL be registered; job_rdy_o=0 outside IDLE; res_val_o=0 outside REPORT.
REQ-031 Total per-candidate latency SHALL be BLOCKS core runs plus 1 CHECK cycle.

Reset
REQ-032 When rst_ni=0, SHALL asynchronously force IDLE, job_rdy_o=0 during reset and 1 after, res_val_o=0, res_hit_o=0, res_last_o=0, res_nonce_o=0, res_dgst_o=0, blk_id=0, and zero init/next.
REQ-033 Reset mid-job SHALL abandon the job with no record emitted; the core is reset through the same rst_ni.

Verification
REQ-034 BLOCKS=1, NONCE_W=8, NONCE_POS=488, msg=0x616263 80 0...0 0x18, nonce=0x60, count=8, mask all-1, target a9993e364706816aba3e25717850c26c9cd0d89d -> one record: hit=1, last=1, nonce=0x63, digest=target, after exactly 4 candidates.
REQ-035 Same job with target da39a3ee5e6b4b0d3255bfef95601890afd80709 -> one record: hit=0, last=1, nonce=0x68, digest=0.
REQ-036 count=0 -> record hit=0, last=1, nonce=start, within 2 cycles of accept; core init is never pulsed.
REQ-037 STOP_ON_HIT=0, mask=0, count=3, res_rdy_i held low for 10 cycles on each record -> 3 records with hit=1 and stable fields while stalled; only the third has last=1.
REQ-038 BLOCKS=2, nonce=0xFF, count=2, NONCE_W=8 -> nonce wraps; init pulsed once and next pulsed once per candidate; final no-hit nonce=0x01.
REQ-039 rst_ni pulsed low while in WAIT -> IDLE with all outputs at reset values on the next edge; a new job afterwards completes correctly.
